// File: rtl/dmem_pkg.sv
// Shared widths, FSM state type and counter helper for the data-memory responder.
package dmem_pkg;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Counter preload: the request cycle and the commit cycle are both part of the busy window.
  function automatic logic [CNT_W-1:0] load_count(input int cycles);
    return CNT_W'(cycles - 2);
  endfunction
endpackage

// File: rtl/dmem_array.sv
// Byte storage with a synchronous write port and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wdata;
    end
  end

  // Read register, cleared by reset and otherwise holding its last value.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory.sv
// Multi-cycle byte data memory for the CPU load/store port: latches the request,
// stalls the CPU with BUSYWAIT for ACCESS_CYCLES, then commits or returns data.
module data_memory
  import dmem_pkg::*;
#(
  parameter int ACCESS_CYCLES = 5,
  parameter int DEPTH         = 256
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] WRITEDATA,
  output logic [DATA_W-1:0] READDATA,
  output logic              BUSYWAIT
);

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_write;
  logic              request;
  logic              busy_raw;
  logic              commit;
  logic              wr_en;
  logic              rd_en;

  assign request = READ | WRITE;

  // Next-state decode and raw stall generation.
  always_comb begin
    next_state = state;
    busy_raw   = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        busy_raw = request;
        if (request) begin
          next_state = ACCESS;
        end else begin
          next_state = IDLE;
        end
      end
      ACCESS: begin
        busy_raw = 1'b1;
        if (cnt == {CNT_W{1'b0}}) begin
          commit     = 1'b1;
          next_state = DONE;
        end else begin
          next_state = ACCESS;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Reset suppresses both the stall and any commit in flight.
  assign BUSYWAIT = busy_raw & ~RESET;
  assign wr_en    = commit & lat_write & ~RESET;
  assign rd_en    = commit & ~lat_write & ~RESET;

  // State, countdown and operand latches.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cnt       <= {CNT_W{1'b0}};
      lat_addr  <= {ADDR_W{1'b0}};
      lat_data  <= {DATA_W{1'b0}};
      lat_write <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (request) begin
            lat_addr  <= ADDRESS;
            lat_data  <= WRITEDATA;
            lat_write <= WRITE;
            cnt       <= load_count(ACCESS_CYCLES);
          end
        end
        ACCESS: begin
          if (cnt != {CNT_W{1'b0}}) begin
            cnt <= cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

  dmem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk   (CLK),
    .reset (RESET),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .addr  (lat_addr),
    .wdata (lat_data),
    .rdata (READDATA)
  );

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: two instances (5-cycle and 2-cycle latency), a
// transaction-timing reference model checked every cycle, directed and random stimulus.
module tb_data_memory;

  logic       clk = 1'b0;
  logic       rst_i  [2];
  logic       rd_i   [2];
  logic       wr_i   [2];
  logic [7:0] addr_i [2];
  logic [7:0] wd_i   [2];
  logic [7:0] rdata0, rdata1;
  logic [1:0] busy_v;

  int n_cmp = 0;
  int n_bad = 0;
  int acs [2] = '{5, 2};

  always #5 clk = ~clk;

  data_memory #(.ACCESS_CYCLES(5), .DEPTH(256)) u_dut5 (
    .CLK(clk), .RESET(rst_i[0]), .READ(rd_i[0]), .WRITE(wr_i[0]),
    .ADDRESS(addr_i[0]), .WRITEDATA(wd_i[0]), .READDATA(rdata0), .BUSYWAIT(busy_v[0])
  );

  data_memory #(.ACCESS_CYCLES(2), .DEPTH(256)) u_dut2 (
    .CLK(clk), .RESET(rst_i[1]), .READ(rd_i[1]), .WRITE(wr_i[1]),
    .ADDRESS(addr_i[1]), .WRITEDATA(wd_i[1]), .READDATA(rdata1), .BUSYWAIT(busy_v[1])
  );

  function automatic logic [7:0] rsel(input int k);
    return (k == 0) ? rdata0 : rdata1;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an access accepted in cycle s is busy in s..s+AC-1,
  // commits at the end of s+AC-1, is in its done cycle at s+AC and frees the port after it.
  int         cyc = 0;
  int         start [2];
  logic [7:0] mmem  [2][256];
  bit         mval  [2][256];
  logic [7:0] rdm   [2];
  bit         rdv   [2];
  logic [7:0] la    [2];
  logic [7:0] ld    [2];
  bit         lw    [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      start[k] = -1;
      rdv[k]   = 1'b0;
      rdm[k]   = 8'h00;
      for (int a = 0; a < 256; a++) mval[k][a] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic exp_busy;
      int   age;
      if (rst_i[k]) exp_busy = 1'b0;
      else if (start[k] >= 0) exp_busy = ((cyc - start[k]) < acs[k]);
      else exp_busy = rd_i[k] | wr_i[k];
      check($sformatf("model_busy%0d", k), {7'd0, busy_v[k]}, {7'd0, exp_busy});
      if (rdv[k]) check($sformatf("model_rdata%0d", k), rsel(k), rdm[k]);

      if (rst_i[k]) begin
        start[k] = -1;
        rdm[k]   = 8'h00;
        rdv[k]   = 1'b1;
      end else if (start[k] >= 0) begin
        age = cyc - start[k];
        if (age == acs[k] - 1) begin
          if (lw[k]) begin
            mmem[k][la[k]] = ld[k];
            mval[k][la[k]] = 1'b1;
          end else begin
            rdm[k] = mmem[k][la[k]];
            rdv[k] = mval[k][la[k]];
          end
        end
        if (age == acs[k]) start[k] = -1;
      end else if (rd_i[k] | wr_i[k]) begin
        start[k] = cyc;
        la[k]    = addr_i[k];
        ld[k]    = wd_i[k];
        lw[k]    = wr_i[k];
      end
    end
    cyc++;
  end

  // One complete access from IDLE; returns stall count over AC+1 cycles and done-cycle values.
  task automatic access(input int k, input logic r, input logic w, input logic [7:0] a,
                        input logic [7:0] d, output int nb, output logic done_busy,
                        output logic [7:0] rd_done);
    nb = 0;
    rd_i[k] = r; wr_i[k] = w; addr_i[k] = a; wd_i[k] = d;
    for (int i = 0; i <= acs[k]; i++) begin
      @(negedge clk);
      if (busy_v[k]) nb++;
      if (i == acs[k]) begin
        done_busy = busy_v[k];
        rd_done   = rsel(k);
      end
      @(posedge clk); #1;
    end
    rd_i[k] = 1'b0; wr_i[k] = 1'b0;
  endtask

  initial begin
    int         nb;
    logic       db;
    logic [7:0] rv;
    for (int k = 0; k < 2; k++) begin
      rst_i[k] = 1'b1; rd_i[k] = 1'b0; wr_i[k] = 1'b0; addr_i[k] = 8'h00; wd_i[k] = 8'h00;
    end

    // Reset then idle.
    repeat (2) begin
      @(negedge clk);
      check("rst_busy", {7'd0, busy_v[0]}, 8'h00);
      @(posedge clk); #1;
    end
    rst_i[0] = 1'b0; rst_i[1] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("idle_busy", {7'd0, busy_v[0]}, 8'h00);
      check("idle_rdata", rdata0, 8'h00);
      @(posedge clk); #1;
    end

    // Write then read.
    access(0, 1'b0, 1'b1, 8'h10, 8'hA5, nb, db, rv);
    check("wr_busy_cycles", 8'(nb), 8'd5);
    check("wr_done_busy", {7'd0, db}, 8'h00);
    access(0, 1'b1, 1'b0, 8'h10, 8'h00, nb, db, rv);
    check("rd_busy_cycles", 8'(nb), 8'd5);
    check("rd_done_busy", {7'd0, db}, 8'h00);
    check("rd_done_data", rv, 8'hA5);

    // Held request: ignored in DONE, restarts in the following IDLE cycle.
    rd_i[0] = 1'b1; addr_i[0] = 8'h10;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i == 5) check("held_done_busy", {7'd0, busy_v[0]}, 8'h00);
      if (i == 6) check("held_restart_busy", {7'd0, busy_v[0]}, 8'h01);
      @(posedge clk); #1;
    end
    rd_i[0] = 1'b0;
    repeat (5) begin @(posedge clk); #1; end

    // Operand latching.
    access(0, 1'b0, 1'b1, 8'h21, 8'h66, nb, db, rv);
    wr_i[0] = 1'b1; addr_i[0] = 8'h20; wd_i[0] = 8'h3C;
    repeat (2) begin @(posedge clk); #1; end
    addr_i[0] = 8'h21; wd_i[0] = 8'hFF;
    repeat (4) begin @(posedge clk); #1; end
    wr_i[0] = 1'b0;
    access(0, 1'b1, 1'b0, 8'h20, 8'h00, nb, db, rv);
    check("latch_addr20", rv, 8'h3C);
    access(0, 1'b1, 1'b0, 8'h21, 8'h00, nb, db, rv);
    check("latch_addr21", rv, 8'h66);

    // Reset aborts a pending write.
    access(0, 1'b0, 1'b1, 8'h30, 8'h11, nb, db, rv);
    wr_i[0] = 1'b1; addr_i[0] = 8'h30; wd_i[0] = 8'h77;
    repeat (3) begin @(posedge clk); #1; end
    rst_i[0] = 1'b1; wr_i[0] = 1'b0;
    @(negedge clk);
    check("abort_busy_in_rst", {7'd0, busy_v[0]}, 8'h00);
    @(posedge clk); #1;
    rst_i[0] = 1'b0;
    @(negedge clk);
    check("abort_busy_after", {7'd0, busy_v[0]}, 8'h00);
    check("abort_rdata", rdata0, 8'h00);
    @(posedge clk); #1;
    access(0, 1'b1, 1'b0, 8'h30, 8'h00, nb, db, rv);
    check("abort_kept_old", rv, 8'h11);

    // Simultaneous READ & WRITE services as write, READDATA untouched.
    access(0, 1'b1, 1'b0, 8'h10, 8'h00, nb, db, rv);
    access(0, 1'b1, 1'b1, 8'h40, 8'h5A, nb, db, rv);
    check("both_rdata_kept", rv, 8'hA5);
    access(0, 1'b1, 1'b0, 8'h40, 8'h00, nb, db, rv);
    check("both_wrote", rv, 8'h5A);

    // Two-cycle instance.
    access(1, 1'b0, 1'b1, 8'h50, 8'hC3, nb, db, rv);
    check("ac2_wr_busy", 8'(nb), 8'd2);
    access(1, 1'b1, 1'b0, 8'h50, 8'h00, nb, db, rv);
    check("ac2_rd_busy", 8'(nb), 8'd2);
    check("ac2_rd_data", rv, 8'hC3);
    access(1, 1'b1, 1'b1, 8'h60, 8'h0F, nb, db, rv);
    check("ac2_both_busy", 8'(nb), 8'd2);
    check("ac2_both_done_busy", {7'd0, db}, 8'h00);
    check("ac2_both_rdata", rv, 8'hC3);
    access(1, 1'b1, 1'b0, 8'h60, 8'h00, nb, db, rv);
    check("ac2_both_wrote", rv, 8'h0F);

    // Random traffic on both instances, including mid-access input changes and resets.
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < 2; k++) begin
        rst_i[k]  = ($urandom_range(0, 79) == 0);
        rd_i[k]   = ($urandom_range(0, 2) == 0);
        wr_i[k]   = ($urandom_range(0, 3) == 0);
        addr_i[k] = 8'hA0 + 8'($urandom_range(0, 15));
        wd_i[k]   = 8'($urandom_range(0, 255));
      end
      @(posedge clk); #1;
    end
    for (int k = 0; k < 2; k++) begin
      rst_i[k] = 1'b0; rd_i[k] = 1'b0; wr_i[k] = 1'b0;
    end
    repeat (20) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
